// File: rtl/ad747x_pkg.sv
// Shared types, constants and helpers for the AD747x multi-channel reader.
// Frame layout and clock-count conversion live here.
package ad747x_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET,
        S_STROBE,
        S_GAP
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;

    function automatic int ceil_clks(input longint freq, input longint ns);
        return int'((freq * ns + longint'(999_999_999)) / longint'(1_000_000_000));
    endfunction

    function automatic bit legal_bits(input int bits);
        return (bits == 12) || (bits == 10) || (bits == 8);
    endfunction

endpackage

// File: rtl/ad747x_sclk_gen.sv
// SCLK phase generator: low phase first, then high, for one 16-period frame.
module ad747x_sclk_gen
    import ad747x_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic fall,
    output logic done
);

    localparam int LOW = CLK_DIV - CLK_DIV / 2;
    localparam int PW  = $clog2(CLK_DIV);

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_n;
    logic          active;
    logic [4:0]    cnt;
    logic          sclk_n;

    always_comb begin
        ph_n = '0;
        if (active && ph != PW'(CLK_DIV - 1)) begin
            ph_n = ph + 1'b1;
        end
        sclk_n = en ? (ph_n >= PW'(LOW)) : 1'b1;
    end

    // en is the look-ahead "next cycle is SHIFT", so fall marks the sampling edge
    assign fall = en && sclk && !sclk_n;
    assign done = (cnt == 5'(FRAME_BITS)) && (ph == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph     <= '0;
            active <= 1'b0;
            cnt    <= '0;
            sclk   <= 1'b1;
        end else if (clr || !en) begin
            ph     <= '0;
            active <= 1'b0;
            cnt    <= '0;
            sclk   <= 1'b1;
        end else begin
            ph     <= ph_n;
            active <= 1'b1;
            sclk   <= sclk_n;
            if (fall) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_register.sv
// Left-shifting serial-in capture register.
module shift_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/timer.sv
// Down-counting interval timer; done is high in the last cycle of a loaded interval.
module timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] ticks,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= ticks - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ad747x_multi_interface.sv
// Multi-channel AD7476A/7477/7478 reader sharing one SCLK/CS# pair.
// One-shot or rate-limited continuous sampling with per-channel framing check.
module ad747x_multi_interface
    import ad747x_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int SCLK_FREQ_HZ    = 20_000_000,
    parameter int CHANNELS        = 1,
    parameter int DATA_BITS       = 12,
    parameter int MIN_PERIOD_CLKS = 100
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          request_i,
    input  logic                          continuous_i,
    output logic                          busy_o,
    output logic [CHANNELS*DATA_BITS-1:0] data_o,
    output logic [CHANNELS-1:0]           frame_err_o,
    output logic                          data_valid_o,
    output logic                          sclk_o,
    output logic                          cs_n_o,
    input  logic [CHANNELS-1:0]           sdata_i
);

    localparam int CLK_DIV = CLK_FREQ_HZ / SCLK_FREQ_HZ;
    localparam int T2_RAW  = ceil_clks(CLK_FREQ_HZ, 10);
    localparam int T2      = (T2_RAW < 1) ? 1 : T2_RAW;
    localparam int QUIET   = ceil_clks(CLK_FREQ_HZ, 86);
    localparam int TMAX    = (T2 > QUIET) ? T2 : QUIET;
    localparam int TW      = $clog2(TMAX + 1);

    if (SCLK_FREQ_HZ > 20_000_000 || CLK_DIV < 2) begin : g_bad_clk
        $error("ad747x: SCLK must be <= 20 MHz with CLK_DIV >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_ch
        $error("ad747x: CHANNELS must be >= 1");
    end
    if (!legal_bits(DATA_BITS)) begin : g_bad_bits
        $error("ad747x: DATA_BITS must be 12, 10 or 8");
    end

    state_t          state;
    state_t          next;
    logic            pend;
    logic [31:0]     pcnt;
    logic            enter_setup;
    logic            period_ok;
    logic            go;
    logic            tmr_start;
    logic            tmr_done;
    logic [TW-1:0]   tmr_ticks;
    logic            sc_fall;
    logic            sc_done;
    logic            cs_d;
    logic            busy_d;
    logic            valid_d;
    logic            load;
    logic [FRAME_BITS-1:0] sh [CHANNELS];

    assign enter_setup = (next == S_SETUP) && (state != S_SETUP);
    assign period_ok   = (pcnt + 32'd1 >= 32'(MIN_PERIOD_CLKS));
    assign go          = continuous_i || pend;
    assign tmr_start   = enter_setup || ((next == S_QUIET) && (state != S_QUIET));
    assign tmr_ticks   = enter_setup ? TW'(T2) : TW'(QUIET);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            cs_n_o       <= 1'b1;
            busy_o       <= 1'b0;
            data_valid_o <= 1'b0;
        end else begin
            state        <= next;
            cs_n_o       <= cs_d;
            busy_o       <= busy_d;
            data_valid_o <= valid_d;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   if (request_i || continuous_i) next = S_SETUP;
            S_SETUP:  if (tmr_done) next = S_SHIFT;
            S_SHIFT:  if (sc_done) next = S_QUIET;
            S_QUIET:  if (tmr_done) next = S_STROBE;
            S_STROBE: next = !go ? S_IDLE : (period_ok ? S_SETUP : S_GAP);
            S_GAP:    if (period_ok) next = go ? S_SETUP : S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_comb begin
        cs_d    = !((next == S_SETUP) || (next == S_SHIFT));
        busy_d  = (next == S_SETUP) || (next == S_SHIFT) ||
                  (next == S_QUIET) || (next == S_STROBE);
        valid_d = (next == S_STROBE);
        load    = (next == S_STROBE) && (state != S_STROBE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= 1'b0;
            pcnt <= '0;
        end else begin
            if (enter_setup) begin
                pend <= 1'b0;
            end else if (request_i && state != S_IDLE) begin
                pend <= 1'b1;
            end
            if (enter_setup) begin
                pcnt <= '0;
            end else if (pcnt < 32'(MIN_PERIOD_CLKS)) begin
                pcnt <= pcnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= '0;
            frame_err_o <= '0;
        end else if (load) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                data_o[ch*DATA_BITS +: DATA_BITS] <=
                    sh[ch][FRAME_BITS-LEAD_ZEROS-1 -: DATA_BITS];
                frame_err_o[ch] <= |sh[ch][FRAME_BITS-1 -: LEAD_ZEROS];
            end
        end
    end

    timer #(.W(TW)) u_timer (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (tmr_start),
        .ticks (tmr_ticks),
        .done  (tmr_done)
    );

    ad747x_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (next == S_SHIFT),
        .clr  (state == S_IDLE),
        .sclk (sclk_o),
        .fall (sc_fall),
        .done (sc_done)
    );

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        shift_register #(.WIDTH(FRAME_BITS)) u_sr (
            .clk (clk_i),
            .rst (rst_i),
            .en  (sc_fall),
            .din (sdata_i[ch]),
            .q   (sh[ch])
        );
    end

endmodule
